// File: rtl/ofz_sz_datapath.sv
// ofz_sz_datapath: Sz coefficient store with FIR MAC and 2-stage LMS update pipeline.
// Define OFZ_LEAK_EN to build the leaky-LMS write path (adds the LK_SHIFT parameter).
module ofz_sz_datapath #(
    parameter int TAPS     = 128,
    parameter int VW       = 16,
    parameter int SW       = 16,
    parameter int FW       = 36,
    parameter int FN_SHIFT = 20,
    parameter int MU_SHIFT = 12,
`ifdef OFZ_LEAK_EN
    parameter int LK_SHIFT = 10,
`endif
    localparam int AW = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 opm_valid,
    input  logic                 lms_valid,
    input  logic [AW-1:0]        sz_addr,
    input  logic signed [VW-1:0] vn_data,
    input  logic signed [FW-1:0] fn,
    input  logic                 sz_clr,
    output logic signed [FW-1:0] yn,
    output logic                 yn_valid,
    output logic                 busy,
    output logic                 collide,
    input  logic [AW-1:0]        sz_rd_addr,
    output logic signed [SW-1:0] sz_rd_data
);
    localparam int AccW = 39;
    localparam int ExtW = 40;

    function automatic logic signed [SW-1:0] sat16(input logic signed [ExtW-1:0] v);
        return (v > ExtW'(32767)) ? 16'sh7FFF : (v < -ExtW'(32768)) ? 16'sh8000 : v[SW-1:0];
    endfunction

    function automatic logic signed [FW-1:0] sat36(input logic signed [AccW-1:0] v);
        return (v > 39'sd34359738367) ? 36'sh7FFFFFFFF :
               (v < -39'sd34359738368) ? 36'sh800000000 : v[FW-1:0];
    endfunction

    logic signed [SW-1:0]   sz_q [TAPS];
    logic signed [AccW-1:0] acc_q, acc_d;
    logic signed [FW-1:0]   yn_q;
    logic                   yn_valid_q, collide_q;
    logic signed [SW-1:0]   rd_q;
    logic                   s1_v_q, s1_v_d, s2_v_q;
    logic [AW-1:0]          s1_addr_q, s2_addr_q;
    logic signed [VW-1:0]   s1_vn_q;
    logic signed [SW-1:0]   s1_sz_q, s1_e_d, s1_e_q, s2_val_q, s2_val_d;
    logic signed [31:0]     p, prod, d;
    logic                   last;

    always_comb begin
        p        = vn_data * sz_q[sz_addr];
        acc_d    = (sz_addr == '0) ? AccW'(p) : acc_q + AccW'(p);
        last     = opm_valid && (sz_addr == AW'(TAPS - 1));
        // opm_valid wins a collision; sz_clr wins over any update
        s1_v_d   = lms_valid && !opm_valid && !sz_clr;
        s1_e_d   = sat16(ExtW'(fn >>> FN_SHIFT));
        prod     = s1_e_q * s1_vn_q;
        d        = prod >>> MU_SHIFT;
`ifdef OFZ_LEAK_EN
        s2_val_d = sat16(ExtW'(s1_sz_q) - ExtW'(s1_sz_q >>> LK_SHIFT) + ExtW'(d));
`else
        s2_val_d = sat16(ExtW'(s1_sz_q) + ExtW'(d));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) sz_q[i] <= '0;
            acc_q      <= '0;
            yn_q       <= '0;
            yn_valid_q <= 1'b0;
            collide_q  <= 1'b0;
            rd_q       <= '0;
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s1_addr_q  <= '0;
            s2_addr_q  <= '0;
            s1_vn_q    <= '0;
            s1_sz_q    <= '0;
            s1_e_q     <= '0;
            s2_val_q   <= '0;
        end else begin
            if (sz_clr) begin
                for (int i = 0; i < TAPS; i++) sz_q[i] <= '0;
            end else if (s2_v_q) begin
                sz_q[s2_addr_q] <= s2_val_q;
            end
            if (opm_valid) acc_q <= acc_d;
            if (last) yn_q <= sat36(acc_d);
            yn_valid_q <= last;
            collide_q  <= collide_q || (opm_valid && lms_valid);
            rd_q       <= sz_q[sz_rd_addr];
            s1_v_q     <= s1_v_d;
            s2_v_q     <= s1_v_q && !sz_clr;
            s1_addr_q  <= sz_addr;
            s1_vn_q    <= vn_data;
            s1_sz_q    <= sz_q[sz_addr];
            s1_e_q     <= s1_e_d;
            s2_addr_q  <= s1_addr_q;
            s2_val_q   <= s2_val_d;
        end
    end

    assign yn         = yn_q;
    assign yn_valid   = yn_valid_q;
    assign busy       = s1_v_q || s2_v_q;
    assign collide    = collide_q;
    assign sz_rd_data = rd_q;
endmodule
